rprelu_para_sched: RTL and testbench
====================================

Name: rprelu_para_sched

Overview:
- Controller for one RPReLU layer stage. Owns the stage's mode signal and its per-channel beta/gamma/zeta parameter registers.
- Loads parameters from a serial word stream (from off-chip/para memory). Drains the 3-stage RPReLU pipeline before any reload.
- Gates the data-enable into the datapath so no sample is processed with half-updated parameters.
- Sits between the BN output, the parameter stream source and the RPReLU datapath.

Parameters:
- CHANNEL_NUM, 256, number of channels (one beta/gamma/zeta triple each).
- PARA_WIDTH, 16, signed parameter word width.
- PIPE_DEPTH, 3, RPReLU datapath latency in cycles, data_e to data_e_out.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- reload_req, in, 1, level or pulse; request a parameter reload.
- para_in, in, PARA_WIDTH, parameter word.
- para_valid, in, 1, para_in valid.
- para_ready, out, 1, word accepted when para_valid && para_ready.
- data_e_in, in, 1, sample-valid from BN.
- stall, out, 1, upstream must hold samples while high.
- data_e_out, out, 1, gated data enable to the RPReLU datapath.
- mode, out, 1, 0 = reload, 1 = calculate; drives the datapath mode.
- rprelu_beta, out, PARA_WIDTH x CHANNEL_NUM (unpacked array), beta per channel.
- rprelu_gamma, out, PARA_WIDTH x CHANNEL_NUM, gamma per channel.
- rprelu_zeta, out, PARA_WIDTH x CHANNEL_NUM, zeta per channel.
- load_done, out, 1, one-cycle pulse when a load completes.
- para_err, out, 1, sticky error flag; used only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: state LOAD, mode 0, para_ready 1, stall 1, data_e_out 0, load_done 0, para_err 0, all parameter registers 0, counters 0.
- States: LOAD, DONE, CALC, DRAIN.
- LOAD:
  - para_ready 1, mode 0, stall 1, data_e_out 0.
  - Word order is bank-major: CHANNEL_NUM beta words (channel 0 first), then CHANNEL_NUM gamma words, then CHANNEL_NUM zeta words. Total 3*CHANNEL_NUM words.
  - chan_cnt increments on each accepted word and wraps to 0 at CHANNEL_NUM-1. bank_cnt (0 = beta, 1 = gamma, 2 = zeta) increments on that wrap.
  - Acceptance of the final word (bank 2, channel CHANNEL_NUM-1) -> DONE.
  - No gaps are required; para_valid low simply stalls the load.
- DONE: exactly one cycle. load_done = 1, para_ready 0, mode 0. Next state CALC; counters cleared.
- CALC:
  - mode 1, stall 0, para_ready 0.
  - data_e_out = data_e_in, combinational pass-through.
  - On reload_req = 1 -> DRAIN next cycle. A data_e_in in that same cycle is still passed.
- DRAIN:
  - mode stays 1 so in-flight samples complete. stall 1, data_e_out 0, and data_e_in is dropped.
  - drain_cnt is loaded with PIPE_DEPTH on entry and decrements each cycle. At 0 -> LOAD, where mode drops to 0.
- Parameter registers are written only on an accepted word in LOAD. They hold their values in all other states, including DRAIN, and mid-load they retain old values for the not-yet-written entries.
- reload_req is ignored in LOAD, DONE and DRAIN; there is no queuing.
- para_valid while para_ready = 0 has no effect.
- Reset mid-load or mid-drain returns to LOAD with all parameters zeroed and counters cleared.

Optional Feature:
- Macro: RPRELU_PARA_CHECKSUM_EN.
- Defined:
  - LOAD expects one extra word after the last zeta: a PARA_WIDTH-bit modulo-2^PARA_WIDTH sum of all 3*CHANNEL_NUM words.
  - Match -> DONE.
  - Mismatch -> para_err set (sticky until reset), counters cleared, and the FSM stays in LOAD for a full re-send. load_done is not pulsed.
  - The running sum clears at every load start.
- Undefined: no checksum word, and para_err tied 0.

Decomposition:
- Shared package rprelu_pkg:
  - state enum (LOAD, DONE, CALC, DRAIN);
  - constants MODE_RELOAD = 0 and MODE_CALC = 1;
  - bank index constants BANK_BETA, BANK_GAMMA, BANK_ZETA;
  - a function returning the word count per load.
- One natural sub-module: rprelu_para_bank. It holds CHANNEL_NUM x PARA_WIDTH registers with a write enable and an index, and is instantiated three times.
- FSM, counters and gating stay in the top.

Test Plan:
- Reset, then 768 words with value = index (beta[c] = c, gamma[c] = 256+c, zeta[c] = 512+c) -> load_done pulses 1 cycle after word 767; mode = 1 the cycle after; beta[5] = 5, zeta[255] = 767.
- CALC with data_e_in toggling -> data_e_out identical, same cycle; stall 0.
- reload_req together with data_e_in = 1 in CALC -> that sample passes; next 3 cycles mode = 1, stall = 1, data_e_out = 0; then mode = 0, para_ready = 1.
- para_valid with 2-cycle gaps -> counters advance only on handshake; the second load overwrites all 768 entries; no early load_done.
- rst_n low at word 400 -> all parameter outputs 0, state LOAD; a fresh 768-word load succeeds.
- With RPRELU_PARA_CHECKSUM_EN: wrong checksum -> para_err = 1, no load_done, and a re-send with the correct checksum completes. Without the macro: para_err stays 0.

Source files
------------

// File: rtl/rprelu_pkg.sv
// rprelu_pkg: shared state, mode and bank definitions for the RPReLU parameter scheduler.
// RPRELU_PARA_CHECKSUM_EN appends one checksum word to every parameter load.
package rprelu_pkg;
   typedef enum logic [1:0] {LOAD, DONE, CALC, DRAIN} state_t;
   localparam logic MODE_RELOAD = 1'b0;
   localparam logic MODE_CALC = 1'b1;
   localparam logic [1:0] BANK_BETA = 2'd0;
   localparam logic [1:0] BANK_GAMMA = 2'd1;
   localparam logic [1:0] BANK_ZETA = 2'd2;
   localparam logic [1:0] BANK_CSUM = 2'd3;
   function automatic int unsigned load_words(input int unsigned channels);
`ifdef RPRELU_PARA_CHECKSUM_EN
      return 3 * channels + 1;
`else
      return 3 * channels;
`endif
   endfunction
endpackage

// File: rtl/rprelu_para_bank.sv
// rprelu_para_bank: one per-channel parameter register file with indexed write.
module rprelu_para_bank #(
   parameter int CHANNEL_NUM = 256,
   parameter int PARA_WIDTH = 16
) (
   input logic clk,
   input logic rst_n,
   input logic we,
   input logic [$clog2(CHANNEL_NUM)-1:0] idx,
   input logic [PARA_WIDTH-1:0] din,
   output logic signed [PARA_WIDTH-1:0] q [CHANNEL_NUM]
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < CHANNEL_NUM; i++) q[i] <= '0;
      else if (we)
         q[idx] <= din;
endmodule

// File: rtl/rprelu_para_sched.sv
// rprelu_para_sched: loads beta/gamma/zeta banks, drains the datapath before reloads, gates data enable.
// Build option RPRELU_PARA_CHECKSUM_EN: trailing checksum word per load, sticky para_err on mismatch.
module rprelu_para_sched
   import rprelu_pkg::*;
#(
   parameter int CHANNEL_NUM = 256,
   parameter int PARA_WIDTH = 16,
   parameter int PIPE_DEPTH = 3
) (
   input logic clk,
   input logic rst_n,
   input logic reload_req,
   input logic [PARA_WIDTH-1:0] para_in,
   input logic para_valid,
   output logic para_ready,
   input logic data_e_in,
   output logic stall,
   output logic data_e_out,
   output logic mode,
   output logic signed [PARA_WIDTH-1:0] rprelu_beta [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM],
   output logic signed [PARA_WIDTH-1:0] rprelu_zeta [CHANNEL_NUM],
   output logic load_done,
   output logic para_err
);
   localparam int CW = $clog2(CHANNEL_NUM);
   localparam int DW = $clog2(PIPE_DEPTH + 1);
   state_t state, state_nxt;
   logic [CW-1:0] chan_cnt;
   logic [1:0] bank_cnt;
   logic [DW-1:0] drain_cnt;
   logic accept, wrap, last_word, sum_ok;
   assign accept = para_valid && para_ready;
   assign wrap = chan_cnt == CW'(CHANNEL_NUM - 1);
`ifdef RPRELU_PARA_CHECKSUM_EN
   logic [PARA_WIDTH-1:0] sum;
   logic err;
   assign last_word = accept && bank_cnt == BANK_CSUM;
   assign sum_ok = para_in == sum;
   assign para_err = err;
   // The sum restarts whenever a load (or a re-send after a mismatch) begins.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sum <= '0;
         err <= 1'b0;
      end else begin
         sum <= (state != LOAD || last_word) ? '0 : accept ? sum + para_in : sum;
         err <= err || (last_word && !sum_ok);
      end
`else
   assign last_word = accept && bank_cnt == BANK_ZETA && wrap;
   assign sum_ok = 1'b1;
   assign para_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= LOAD;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         chan_cnt <= '0;
         bank_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         drain_cnt <= (state == DRAIN) ? drain_cnt - DW'(1) : DW'(PIPE_DEPTH);
         if (state != LOAD || last_word) begin
            chan_cnt <= '0;
            bank_cnt <= '0;
         end else if (accept) begin
            chan_cnt <= wrap ? '0 : chan_cnt + CW'(1);
            bank_cnt <= wrap ? bank_cnt + 2'd1 : bank_cnt;
         end
      end
   always_comb begin
      state_nxt = state;
      mode = MODE_RELOAD;
      para_ready = 1'b0;
      stall = 1'b1;
      data_e_out = 1'b0;
      load_done = 1'b0;
      case (state)
         LOAD: begin
            para_ready = 1'b1;
            state_nxt = (last_word && sum_ok) ? DONE : LOAD;
         end
         DONE: begin
            load_done = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            mode = MODE_CALC;
            stall = 1'b0;
            data_e_out = data_e_in;
            state_nxt = reload_req ? DRAIN : CALC;
         end
         DRAIN: begin
            mode = MODE_CALC;
            state_nxt = (drain_cnt <= DW'(1)) ? LOAD : DRAIN;
         end
      endcase
   end
   rprelu_para_bank #(.CHANNEL_NUM(CHANNEL_NUM), .PARA_WIDTH(PARA_WIDTH)) u_beta (
      .clk(clk), .rst_n(rst_n), .we(accept && bank_cnt == BANK_BETA),
      .idx(chan_cnt), .din(para_in), .q(rprelu_beta));
   rprelu_para_bank #(.CHANNEL_NUM(CHANNEL_NUM), .PARA_WIDTH(PARA_WIDTH)) u_gamma (
      .clk(clk), .rst_n(rst_n), .we(accept && bank_cnt == BANK_GAMMA),
      .idx(chan_cnt), .din(para_in), .q(rprelu_gamma));
   rprelu_para_bank #(.CHANNEL_NUM(CHANNEL_NUM), .PARA_WIDTH(PARA_WIDTH)) u_zeta (
      .clk(clk), .rst_n(rst_n), .we(accept && bank_cnt == BANK_ZETA),
      .idx(chan_cnt), .din(para_in), .q(rprelu_zeta));
endmodule

// File: tb/tb_rprelu_para_sched.sv
// tb_rprelu_para_sched: directed bench for load, calc pass-through, drain, gapped reload and mid-load reset.
// Optionally built with RPRELU_PARA_CHECKSUM_EN to exercise the checksum path.
module tb_rprelu_para_sched;
   localparam int CH = 256;
   localparam int PW = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic reload_req = 1'b0;
   logic [PW-1:0] para_in = '0;
   logic para_valid = 1'b0;
   logic para_ready;
   logic data_e_in = 1'b0;
   logic stall, data_e_out, mode, load_done, para_err;
   logic signed [PW-1:0] beta [CH];
   logic signed [PW-1:0] gamma [CH];
   logic signed [PW-1:0] zeta [CH];
   int n_vec = 0;
   int n_bad = 0;

   rprelu_para_sched #(.CHANNEL_NUM(CH), .PARA_WIDTH(PW), .PIPE_DEPTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .reload_req(reload_req), .para_in(para_in),
      .para_valid(para_valid), .para_ready(para_ready), .data_e_in(data_e_in),
      .stall(stall), .data_e_out(data_e_out), .mode(mode), .rprelu_beta(beta),
      .rprelu_gamma(gamma), .rprelu_zeta(zeta), .load_done(load_done), .para_err(para_err));

   always #5 clk = ~clk;

   // Sends n data words base+i; a full load also gets its checksum word when enabled.
   task automatic send_load(input int base, input int gap, input int n, input bit bad_sum, output bit early);
      logic [PW-1:0] sum;
      sum = '0;
      early = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0)
            repeat (gap) begin
               if (load_done) early = 1'b1;
               @(posedge clk); #1;
            end
         para_in = PW'(base + i);
         para_valid = 1'b1;
         sum = sum + para_in;
         if (load_done) early = 1'b1;
         @(posedge clk); #1;
         para_valid = 1'b0;
      end
`ifdef RPRELU_PARA_CHECKSUM_EN
      if (n == 3 * CH) begin
         para_in = bad_sum ? sum + 16'd1 : sum;
         para_valid = 1'b1;
         if (load_done) early = 1'b1;
         @(posedge clk); #1;
         para_valid = 1'b0;
      end
`else
      if (bad_sum) early = 1'b1;
`endif
   endtask

   task automatic check_done(input string tag);
      n_vec++;
      if (load_done !== 1'b1 || mode !== 1'b0 || para_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done: load_done=%b mode=%b para_ready=%b, required 1 0 0", tag, load_done, mode, para_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (load_done !== 1'b0 || mode !== 1'b1 || stall !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_calc: load_done=%b mode=%b stall=%b, required 0 1 0", tag, load_done, mode, stall);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({mode, para_ready, stall, data_e_out, load_done, para_err} !== 6'b011000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b required 011000", {mode, para_ready, stall, data_e_out, load_done, para_err});
      end
      n_vec++;
      if (beta[0] !== 16'sd0 || gamma[128] !== 16'sd0 || zeta[255] !== 16'sd0) begin
         n_bad++;
         $display("FAIL reset_params: got %0d %0d %0d required 0 0 0", beta[0], gamma[128], zeta[255]);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_first_load;
      bit early;
      reload_req = 1'b1;
      send_load(0, 0, 3 * CH, 1'b0, early);
      reload_req = 1'b0;
      n_vec++;
      if (early !== 1'b0) begin
         n_bad++;
         $display("FAIL load1_early: got %b required 0", early);
      end
      check_done("load1");
      n_vec++;
      if (beta[5] !== 16'sd5 || gamma[0] !== 16'sd256 || zeta[255] !== 16'sd767) begin
         n_bad++;
         $display("FAIL load1_values: got %0d %0d %0d required 5 256 767", beta[5], gamma[0], zeta[255]);
      end
   endtask

   task automatic test_calc;
      logic [7:0] pat;
      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         data_e_in = pat[i];
         #1;
         n_vec++;
         if (data_e_out !== pat[i] || stall !== 1'b0 || mode !== 1'b1) begin
            n_bad++;
            $display("FAIL calc_pass[%0d]: data_e_out=%b stall=%b mode=%b required %b 0 1", i, data_e_out, stall, mode, pat[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_drain;
      reload_req = 1'b1;
      data_e_in = 1'b1;
      #1;
      n_vec++;
      if (data_e_out !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_last_sample: got %b required 1", data_e_out);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         reload_req = 1'b1;
         n_vec++;
         if (mode !== 1'b1 || stall !== 1'b1 || data_e_out !== 1'b0 || para_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL drain[%0d]: mode=%b stall=%b data_e_out=%b para_ready=%b required 1 1 0 0", i, mode, stall, data_e_out, para_ready);
         end
         @(posedge clk); #1;
      end
      reload_req = 1'b0;
      data_e_in = 1'b0;
      n_vec++;
      if (mode !== 1'b0 || para_ready !== 1'b1 || stall !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_to_load: mode=%b para_ready=%b stall=%b required 0 1 1", mode, para_ready, stall);
      end
   endtask

   task automatic test_gap_load;
      bit early;
      send_load(1000, 2, 3 * CH, 1'b0, early);
      n_vec++;
      if (early !== 1'b0) begin
         n_bad++;
         $display("FAIL gap_early: got %b required 0", early);
      end
      check_done("gap");
      n_vec++;
      if (beta[0] !== 16'sd1000 || gamma[10] !== 16'sd1266 || zeta[255] !== 16'sd1767) begin
         n_bad++;
         $display("FAIL gap_values: got %0d %0d %0d required 1000 1266 1767", beta[0], gamma[10], zeta[255]);
      end
   endtask

   task automatic test_reset_midload;
      bit early;
      test_drain();
      send_load(2000, 0, 400, 1'b0, early);
      n_vec++;
      if (gamma[143] !== 16'sd2399 || gamma[144] !== 16'sd1400 || load_done !== 1'b0) begin
         n_bad++;
         $display("FAIL partial_retain: got %0d %0d done=%b required 2399 1400 0", gamma[143], gamma[144], load_done);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (beta[0] !== 16'sd0 || gamma[143] !== 16'sd0 || zeta[200] !== 16'sd0 || mode !== 1'b0 || para_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midload_reset: got %0d %0d %0d mode=%b ready=%b required 0 0 0 0 1", beta[0], gamma[143], zeta[200], mode, para_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_load(0, 0, 3 * CH, 1'b0, early);
      check_done("fresh");
      n_vec++;
      if (beta[100] !== 16'sd100 || gamma[255] !== 16'sd511 || zeta[0] !== 16'sd512) begin
         n_bad++;
         $display("FAIL fresh_values: got %0d %0d %0d required 100 511 512", beta[100], gamma[255], zeta[0]);
      end
   endtask

   task automatic test_para_err;
      bit early;
      test_drain();
`ifdef RPRELU_PARA_CHECKSUM_EN
      send_load(300, 0, 3 * CH, 1'b1, early);
      n_vec++;
      if (para_err !== 1'b1 || load_done !== 1'b0 || para_ready !== 1'b1 || early !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_checksum: err=%b done=%b ready=%b early=%b required 1 0 1 0", para_err, load_done, para_ready, early);
      end
      send_load(300, 0, 3 * CH, 1'b0, early);
      check_done("resend");
      n_vec++;
      if (para_err !== 1'b1 || zeta[255] !== 16'sd1067) begin
         n_bad++;
         $display("FAIL resend_values: err=%b zeta255=%0d required 1 1067", para_err, zeta[255]);
      end
`else
      send_load(300, 0, 3 * CH, 1'b0, early);
      check_done("plain");
      n_vec++;
      if (para_err !== 1'b0 || zeta[255] !== 16'sd1067) begin
         n_bad++;
         $display("FAIL para_err_tied: err=%b zeta255=%0d required 0 1067", para_err, zeta[255]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_calc();
      test_drain();
      test_gap_load();
      test_reset_midload();
      test_para_err();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
